vga_scanout: RTL and testbench

Read side of the 1-bit pixel framebuffer. The line drawer and screen-clear logic write pixels into the framebuffer; this block reads them back in raster order and drives the DE1-SoC VGA DAC pins. It generates 640x480@60 timing from the 50 MHz system clock using a divide-by-2 pixel enable. It issues one read per active pixel, with 1-clk memory read latency, and registers colour and sync so that all VGA outputs stay aligned.

---
 rtl/vga_timing_pkg.sv | 15 +
 rtl/vga_sync_counter.sv | 40 ++++
 rtl/vga_scanout.sv | 78 +++++++
 tb/tb_vga_scanout.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and raster coordinate types
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef logic [9:0] x_t;
  typedef logic [8:0] y_t;
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: raster position counters and raw active/sync decode
module vga_sync_counter
  import vga_timing_pkg::x_t;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  output x_t   h_cnt,
  output x_t   v_cnt,
  output logic active,
  output logic hs_raw,
  output logic vs_raw,
  output logic frame_wrap
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic h_last;
  assign h_last = h_cnt == x_t'(H_TOTAL - 1);
  always_ff @(posedge clk)
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= (v_cnt == x_t'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end
  assign active = (h_cnt < x_t'(H_ACTIVE)) && (v_cnt < x_t'(V_ACTIVE));
  assign hs_raw = !((h_cnt >= x_t'(H_ACTIVE + H_FP)) && (h_cnt < x_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = !((v_cnt >= x_t'(V_ACTIVE + V_FP)) && (v_cnt < x_t'(V_ACTIVE + V_FP + V_SYNC)));
  assign frame_wrap = (h_cnt == '0) && (v_cnt == '0);
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster-order framebuffer reader driving the DE1-SoC VGA DAC with 2-clk aligned outputs
module vga_scanout
  import vga_timing_pkg::x_t, vga_timing_pkg::y_t;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       rd_en,
  output x_t         rd_x,
  output y_t         rd_y,
  input  logic       rd_data,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_start
);
  logic pix_en, active, hs_raw, vs_raw, frame_wrap, act_d, hs_d, vs_d;
  x_t h_cnt, v_cnt;
  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .frame_wrap(frame_wrap)
  );
  assign VGA_SYNC_N = 1'b0;
  always_ff @(posedge clk)
    if (reset) begin
      pix_en <= 1'b0;
      VGA_CLK <= 1'b0;
      rd_en <= 1'b0;
      rd_x <= '0;
      rd_y <= '0;
      frame_start <= 1'b0;
      act_d <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
      VGA_CLK <= pix_en;
      rd_en <= pix_en & active;
      frame_start <= pix_en & frame_wrap;
      if (pix_en) begin
        rd_x <= h_cnt;
        rd_y <= y_t'(v_cnt);
        act_d <= active;
        hs_d <= hs_raw;
        vs_d <= vs_raw;
        // rd_data here answers the read issued one pixel period earlier
        VGA_R <= act_d ? {8{rd_data}} : 8'h00;
        VGA_G <= act_d ? {8{rd_data}} : 8'h00;
        VGA_B <= act_d ? {8{rd_data}} : 8'h00;
        VGA_HS <= hs_d;
        VGA_VS <= vs_d;
        VGA_BLANK_N <= act_d;
      end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench with real line timing and a shortened frame height
module tb_vga_scanout;
  localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48, HT = 800;
  localparam int VA = 6, VFP = 2, VSW = 2, VBP = 2, VT = 12;
  typedef struct packed {logic [7:0] rgb; logic hs; logic vs; logic blank;} exp_t;
  logic clk = 0, reset = 1, rd_data = 0;
  logic rd_en, hs, vs, blank_n, sync_n, vga_clk, frame_start;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic [7:0] r, g, b;
  int compared = 0, mismatched = 0, mode = 0;
  exp_t sb[$];
  always #10 clk = ~clk;
  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
    .VGA_SYNC_N(sync_n), .VGA_CLK(vga_clk), .frame_start(frame_start)
  );
  function automatic logic pix(input logic [9:0] x, input logic [8:0] y);
    return (mode == 1) || (x == 10'd5 && y == 9'd3);
  endfunction
  always @(posedge clk) rd_data <= rd_en ? pix(rd_x, rd_y) : 1'($urandom);
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1;
    repeat (n) @(negedge clk);
    reset = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    compared++;
    if ({rd_en, rd_x, rd_y} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_rd got en=%b x=%0d y=%0d want 0 0 0", rd_en, rd_x, rd_y);
    end
    compared++;
    if ({r, g, b} !== 24'h0) begin
      mismatched++;
      $display("FAIL reset_rgb got %h%h%h want 000000", r, g, b);
    end
    compared++;
    if ({hs, vs, blank_n} !== 3'b110) begin
      mismatched++;
      $display("FAIL reset_sync got hs=%b vs=%b blank_n=%b want 1 1 0", hs, vs, blank_n);
    end
    compared++;
    if ({frame_start, vga_clk, sync_n} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_misc got fs=%b vga_clk=%b sync_n=%b want 0 0 0", frame_start, vga_clk, sync_n);
    end
  endtask
  task automatic test_line_timing;
    int t656 = -1, bl = 0, d_low, d_per, d_lat;
    int hf[$], hr[$];
    logic phs = 1;
    mode = 1;
    do_reset(2);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (t656 < 0 && rd_x == 10'd656) t656 = n;
      if (phs && !hs) hf.push_back(n);
      if (!phs && hs) hr.push_back(n);
      if (n < 1600 && blank_n) bl++;
      phs = hs;
    end
    d_low = (hf.size() > 0 && hr.size() > 0) ? hr[0] - hf[0] : -1;
    d_per = (hf.size() > 1) ? hf[1] - hf[0] : -1;
    d_lat = (hf.size() > 0) ? hf[0] - t656 : -1;
    compared++;
    if (d_low != 192) begin
      mismatched++;
      $display("FAIL hs_low_width got %0d want 192", d_low);
    end
    compared++;
    if (d_per != 1600) begin
      mismatched++;
      $display("FAIL hs_period got %0d want 1600", d_per);
    end
    compared++;
    if (d_lat != 2) begin
      mismatched++;
      $display("FAIL hs_latency got %0d want 2", d_lat);
    end
    compared++;
    if (bl != 1280) begin
      mismatched++;
      $display("FAIL blank_high got %0d want 1280", bl);
    end
  endtask
  task automatic test_frame(input int m);
    exp_t cur, e;
    int p, h, v, rd_cnt = 0, ff_cnt = 0, vs_lo = 0, d_fs;
    int fs[$];
    logic act;
    mode = m;
    sb.delete();
    cur = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, blank: 1'b0};
    do_reset(2);
    for (int n = 0; n < 2 * HT * VT + 8; n++) begin
      @(negedge clk);
      if (n % 2 == 1) begin
        p = (n - 1) / 2;
        h = p % HT;
        v = (p / HT) % VT;
        act = (h < HA) && (v < VA);
        compared++;
        if ({rd_en, rd_x, rd_y, frame_start} !== {act, 10'(h), 9'(v), p % (HT * VT) == 0}) begin
          mismatched++;
          $display("FAIL stage0 n=%0d got en=%b x=%0d y=%0d fs=%b want %b %0d %0d %b",
                   n, rd_en, rd_x, rd_y, frame_start, act, h, v, p % (HT * VT) == 0);
        end
        e.rgb = (act && pix(10'(h), 9'(v))) ? 8'hFF : 8'h00;
        e.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
        e.vs = !(v >= VA + VFP && v < VA + VFP + VSW);
        e.blank = act;
        sb.push_back(e);
      end else begin
        compared++;
        if ({rd_en, frame_start} !== 2'b00) begin
          mismatched++;
          $display("FAIL strobe_width n=%0d got en=%b fs=%b want 0 0", n, rd_en, frame_start);
        end
      end
      if (n >= 3 && n % 2 == 1 && sb.size() > 0) cur = sb.pop_front();
      compared++;
      if ({r, g, b, hs, vs, blank_n} !== {cur.rgb, cur.rgb, cur.rgb, cur.hs, cur.vs, cur.blank}) begin
        mismatched++;
        $display("FAIL pins n=%0d got rgb=%h%h%h hs=%b vs=%b bn=%b want %h hs=%b vs=%b bn=%b",
                 n, r, g, b, hs, vs, blank_n, cur.rgb, cur.hs, cur.vs, cur.blank);
      end
      compared++;
      if ({vga_clk, sync_n} !== {n % 2 == 1, 1'b0}) begin
        mismatched++;
        $display("FAIL vga_clk n=%0d got clk=%b sync_n=%b want %b 0", n, vga_clk, sync_n, n % 2 == 1);
      end
      if (n < 2 * HT * VT) begin
        rd_cnt += int'(rd_en);
        ff_cnt += int'(r == 8'hFF);
        vs_lo += int'(!vs);
      end
      if (frame_start) fs.push_back(n);
    end
    compared++;
    if (rd_cnt != HA * VA) begin
      mismatched++;
      $display("FAIL read_count mode=%0d got %0d want %0d", m, rd_cnt, HA * VA);
    end
    compared++;
    if (ff_cnt != (m == 1 ? 2 * HA * VA : 2)) begin
      mismatched++;
      $display("FAIL white_cycles mode=%0d got %0d want %0d", m, ff_cnt, m == 1 ? 2 * HA * VA : 2);
    end
    compared++;
    if (vs_lo != 3200) begin
      mismatched++;
      $display("FAIL vs_low mode=%0d got %0d want 3200", m, vs_lo);
    end
    d_fs = (fs.size() == 2) ? fs[1] - fs[0] : -1;
    compared++;
    if (d_fs != 2 * HT * VT) begin
      mismatched++;
      $display("FAIL frame_period mode=%0d got %0d want %0d", m, d_fs, 2 * HT * VT);
    end
  endtask
  task automatic test_reset_mid;
    int tgt = 1 + 2 * (4 * HT + 300), hf = -1, hr = -1;
    logic phs = 1;
    mode = 1;
    do_reset(2);
    for (int n = 0; n <= tgt; n++) @(negedge clk);
    compared++;
    if ({rd_x, rd_y, r} !== {10'd300, 9'd4, 8'hFF}) begin
      mismatched++;
      $display("FAIL mid_position got x=%0d y=%0d r=%h want 300 4 ff", rd_x, rd_y, r);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    compared++;
    if ({rd_en, rd_x, rd_y, frame_start, r, g, b, hs, vs, blank_n, vga_clk} !==
        {1'b0, 10'd0, 9'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_reset_values got en=%b x=%0d y=%0d fs=%b rgb=%h%h%h hs=%b vs=%b bn=%b clk=%b",
               rd_en, rd_x, rd_y, frame_start, r, g, b, hs, vs, blank_n, vga_clk);
    end
    for (int n = 0; n < 1700; n++) begin
      @(negedge clk);
      if (n < 2) begin
        compared++;
        if ({frame_start, rd_en} !== {2{n == 1}}) begin
          mismatched++;
          $display("FAIL restart_fs n=%0d got fs=%b en=%b want %b", n, frame_start, rd_en, n == 1);
        end
      end
      if (phs && !hs) hf = n;
      if (!phs && hs) hr = n;
      phs = hs;
    end
    compared++;
    if (hf != 1315 || hr - hf != 192) begin
      mismatched++;
      $display("FAIL restart_hs got start=%0d width=%0d want 1315 192", hf, hr - hf);
    end
  endtask
  initial begin
    test_reset;
    test_line_timing;
    test_frame(0);
    test_frame(1);
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
